// File: rtl/rate_mult_pkg.sv
// Shared definitions for the rate-multiplier decoder and its window counter.
// Contents:
//   state_t      - decoder FSM states
//   WIN_LOG2_DEF - default log2 of the measurement window length
//   win_len()    - window length in strobes, 2^win_log2
package rate_mult_pkg;

  localparam int WIN_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // The result is 64 bits wide so that win_log2 = 32 still fits.
  function automatic logic [63:0] win_len(input int win_log2);
    return 64'd1 << win_log2;
  endfunction

endpackage

// File: rtl/rate_mult_decoder_if.sv
// Result handshake between the rate decoder and its consumer.
// Signals:
//   rate_out   - recovered rate word (CW bits)
//   rate_valid - rate_out holds a completed result
//   rate_ready - consumer accepts the result
// Modports: master = decoder side, slave = consumer side.
interface rate_mult_decoder_if #(
  parameter int CW = 9
);

  logic [CW-1:0] rate_out;
  logic          rate_valid;
  logic          rate_ready;

  modport master (
    output rate_out,
    output rate_valid,
    input  rate_ready
  );

  modport slave (
    input  rate_out,
    input  rate_valid,
    output rate_ready
  );

endinterface

// File: rtl/rate_win_counter.sv
// Strobe counter for one measurement window, with terminal-count detect.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   clr   - synchronous clear to zero (wins over en)
//   en    - count one accepted strobe this cycle
//   tc    - the strobe accepted this cycle is the last one of the window
// The count is WIN_LOG2+1 bits, so it reaches 2^WIN_LOG2 on the closing
// strobe instead of wrapping back to zero.
module rate_win_counter
  import rate_mult_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int CW       = WIN_LOG2 + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(win_len(WIN_LOG2) - 64'd1);

  logic [CW-1:0] strobe_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_cnt <= '0;
    end else if (clr) begin
      strobe_cnt <= '0;
    end else if (en) begin
      strobe_cnt <= strobe_cnt + 1'b1;
    end
  end

  assign tc = en && (strobe_cnt == LAST);

endmodule

// File: rtl/rate_mult_decoder.sv
// Receiving end of a binary rate-multiplier pulse stream. It counts pulses
// that coincide with strobes over a window of 2^WIN_LOG2 strobes. It then
// offers the count on a valid/ready handshake. It also flags pulses that
// arrive without a strobe.
// Ports:
//   clock, reset - rising-edge clock, async active-high reset
//   clear        - synchronous abort to IDLE; also clears proto_err
//   start        - begin a window (IDLE, or HOLD together with handshake)
//   strobe       - input event enable (generator X)
//   pulse_in     - rate multiplier output (generator Z)
//   res          - result handshake (rate_out / rate_valid / rate_ready)
//   busy         - window in progress
//   window_done  - high during the cycle the closing strobe is accepted
//   proto_err    - sticky: pulse_in without strobe while measuring
//
// state   | meaning
// IDLE    | waiting for start; strobes and pulses ignored
// MEASURE | window open, counting strobes and coincident pulses
// HOLD    | result presented, waiting for rate_ready
module rate_mult_decoder
  import rate_mult_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int CW       = WIN_LOG2 + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                start,
  input  logic                strobe,
  input  logic                pulse_in,
  rate_mult_decoder_if.master res,
  output logic                busy,
  output logic                window_done,
  output logic                proto_err
);

  state_t        state_q, state_d;
  logic [CW-1:0] pulse_cnt;
  logic [CW-1:0] rate_q;
  logic          in_meas;
  logic          accept;
  logic          handshake;
  logic          start_win;
  logic          tc;

  assign in_meas   = (state_q == MEASURE);
  assign accept    = in_meas && strobe && !clear;
  assign handshake = (state_q == HOLD) && res.rate_ready;
  // A new window can start from IDLE or straight out of a handshake, so
  // back-to-back windows lose no cycle.
  assign start_win = !clear && start && ((state_q == IDLE) || handshake);

  rate_win_counter #(
    .WIN_LOG2 (WIN_LOG2),
    .CW       (CW)
  ) u_win_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start_win || clear),
    .en    (accept),
    .tc    (tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = MEASURE;
        MEASURE: if (tc) state_d = HOLD;
        HOLD:    if (res.rate_ready) state_d = start ? MEASURE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_cnt <= '0;
      rate_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (start_win) begin
        pulse_cnt <= '0;
      end else if (accept && pulse_in) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end

      // Include the closing strobe's own pulse. The sum peaks at 2^WIN_LOG2,
      // which still fits in CW bits.
      if (tc) begin
        rate_q <= pulse_cnt + CW'(pulse_in);
      end

      if (clear) begin
        proto_err <= 1'b0;
      end else if (in_meas && pulse_in && !strobe) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign res.rate_out   = rate_q;
  assign res.rate_valid = (state_q == HOLD);
  assign busy           = in_meas;
  assign window_done    = tc;

endmodule

// File: tb/tb_rate_mult_decoder.sv
// Directed bench for rate_mult_decoder: a WIN_LOG2=4 instance for window,
// handshake, clear and reset behaviour, and a WIN_LOG2=8 instance fed by a
// small binary-rate-multiplier model for loop-back rates.
module tb_rate_mult_decoder;

  logic clock = 1'b0;
  logic reset, clear, strobe, pulse_in;
  logic start4, start8;
  logic busy4, wd4, pe4;
  logic busy8, wd8, pe8;

  int n_cmp = 0;
  int n_mis = 0;
  int wd_seen;
  int busy_low;

  rate_mult_decoder_if #(.CW(5)) r4 ();
  rate_mult_decoder_if #(.CW(9)) r8 ();

  rate_mult_decoder #(.WIN_LOG2(4), .CW(5)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .start       (start4),
    .strobe      (strobe),
    .pulse_in    (pulse_in),
    .res         (r4),
    .busy        (busy4),
    .window_done (wd4),
    .proto_err   (pe4)
  );

  rate_mult_decoder #(.WIN_LOG2(8), .CW(9)) dut8 (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .start       (start8),
    .strobe      (strobe),
    .pulse_in    (pulse_in),
    .res         (r8),
    .busy        (busy8),
    .window_done (wd8),
    .proto_err   (pe8)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // n strobes on consecutive cycles; strobes 1..pulse_upto carry a pulse.
  task automatic run_strobes(input int n, input int pulse_upto);
    for (int k = 1; k <= n; k++) begin
      strobe   = 1'b1;
      pulse_in = (k <= pulse_upto);
      #1;
      if (wd4) wd_seen++;
      if (!busy4) busy_low++;
      tick();
    end
    strobe   = 1'b0;
    pulse_in = 1'b0;
  endtask

  // Binary rate multiplier: weight 1/2 fires on odd n, weight 1/4 on n%4==2.
  function automatic logic gen_z(input logic [7:0] n, input logic c1, input logic c2);
    return (c1 && n[0]) || (c2 && (n[1:0] == 2'b10));
  endfunction

  task automatic loopback(input logic c1, input logic c2, input int exp, input string tag);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int n = 0; n < 256; n++) begin
      strobe   = 1'b1;
      pulse_in = gen_z(8'(n), c1, c2);
      tick();
    end
    strobe   = 1'b0;
    pulse_in = 1'b0;
    chk({tag, "_valid"}, 64'(r8.rate_valid), 64'd1);
    chk({tag, "_rate"}, 64'(r8.rate_out), 64'(exp));
    r8.rate_ready = 1'b1;
    tick();
    r8.rate_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; strobe = 1'b0; pulse_in = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    r4.rate_ready = 1'b0; r8.rate_ready = 1'b0;
    #12;
    reset = 1'b0;
    tick();

    chk("rst_valid", 64'(r4.rate_valid), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_perr", 64'(pe4), 64'd0);
    chk("rst_rate", 64'(r4.rate_out), 64'd0);
    chk("rst_wd", 64'(wd4), 64'd0);

    // Full window, every strobe pulsed.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t1_busy_start", 64'(busy4), 64'd1);
    wd_seen = 0; busy_low = 0;
    run_strobes(16, 16);
    chk("t1_wd_count", 64'(wd_seen), 64'd1);
    chk("t1_busy_during", 64'(busy_low), 64'd0);
    chk("t1_valid", 64'(r4.rate_valid), 64'd1);
    chk("t1_rate", 64'(r4.rate_out), 64'd16);
    chk("t1_busy_after", 64'(busy4), 64'd0);
    chk("t1_wd_after", 64'(wd4), 64'd0);
    chk("t1_perr", 64'(pe4), 64'd0);
    r4.rate_ready = 1'b1;
    tick();
    r4.rate_ready = 1'b0;
    chk("t1_valid_drop", 64'(r4.rate_valid), 64'd0);

    // Strobes every other cycle, pulses on strobes 1,3,5,7,9.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 31; i++) begin
      strobe   = (i % 2 == 0);
      pulse_in = strobe && ((i / 2) % 2 == 0) && (i / 2 < 9);
      #1;
      if (!busy4) busy_low++;
      tick();
    end
    strobe = 1'b0; pulse_in = 1'b0;
    chk("t2_busy_during", 64'(busy_low), 64'd0);
    chk("t2_busy_after", 64'(busy4), 64'd0);
    chk("t2_rate", 64'(r4.rate_out), 64'd5);

    // HOLD with no ready for 5 cycles; start must be ignored.
    busy_low = 0;
    start4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (r4.rate_out !== 5'd5 || !r4.rate_valid || busy4) busy_low++;
    end
    chk("t3_hold_stable", 64'(busy_low), 64'd0);
    r4.rate_ready = 1'b1;
    tick();
    r4.rate_ready = 1'b0;
    start4 = 1'b0;
    chk("t3_b2b_busy", 64'(busy4), 64'd1);
    chk("t3_b2b_valid", 64'(r4.rate_valid), 64'd0);
    run_strobes(16, 3);
    chk("t3_rate", 64'(r4.rate_out), 64'd3);
    r4.rate_ready = 1'b1;
    tick();
    r4.rate_ready = 1'b0;

    // Protocol error handling.
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk("t4_perr_idle", 64'(pe4), 64'd0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run_strobes(4, 4);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk("t4_perr_set", 64'(pe4), 64'd1);
    run_strobes(12, 0);
    chk("t4_rate", 64'(r4.rate_out), 64'd4);
    r4.rate_ready = 1'b1;
    tick();
    r4.rate_ready = 1'b0;
    chk("t4_perr_sticky", 64'(pe4), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_perr_clear", 64'(pe4), 64'd0);
    chk("t4_rate_kept", 64'(r4.rate_out), 64'd4);

    // Clear mid-window aborts to IDLE.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run_strobes(3, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clear_busy", 64'(busy4), 64'd0);
    chk("t5_clear_valid", 64'(r4.rate_valid), 64'd0);

    // Async reset after 7 of 16 strobes.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run_strobes(7, 7);
    reset = 1'b1;
    #1;
    chk("t6_rst_rate", 64'(r4.rate_out), 64'd0);
    chk("t6_rst_busy", 64'(busy4), 64'd0);
    chk("t6_rst_wd", 64'(wd4), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wd_seen = 0;
    run_strobes(16, 10);
    chk("t6_rate", 64'(r4.rate_out), 64'd10);
    chk("t6_wd_count", 64'(wd_seen), 64'd1);
    r4.rate_ready = 1'b1;
    tick();
    r4.rate_ready = 1'b0;

    // Loop-back rates with WIN_LOG2=8.
    loopback(1'b1, 1'b0, 128, "lb_c1");
    loopback(1'b0, 1'b1, 64, "lb_c2");
    loopback(1'b1, 1'b1, 192, "lb_c12");
    chk("lb_perr", 64'(pe8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
